// File: rtl/pes_fmul_pkg.sv
// rtl/pes_fmul_pkg.sv - shared constants and delay-line entry types for the FP32 multiplier arbiter
package pes_fmul_pkg;

    localparam int FP32_W = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] FP_BIAS = 8'h7F;

    localparam int MUL_LAT_DEF = 4;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_W = 3;

    // Delay-line entry when zero/denormal flushing is built in.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             zflag;
        logic             zsign;
    } dl_entry_t;

    // Delay-line entry for the raw-product build.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } dl_base_t;

    // A zero exponent field means zero or denormal; both get flushed.
    function automatic logic exp_is_zero(input logic [FP32_W-1:0] x);
        return x[FP32_W-2 -: EXP_W] == '0;
    endfunction

endpackage

// File: rtl/pes_fmul_rsp_fifo.sv
// rtl/pes_fmul_rsp_fifo.sv - per-requester response FIFO (sync, async active-low reset)
module pes_fmul_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_tvalid_i,
    input  logic [WIDTH-1:0] wr_tdata_i,
    output logic             rd_tvalid_o,
    input  logic             rd_tready_i,
    output logic [WIDTH-1:0] rd_tdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             pop;

    assign pop         = rd_tvalid_o && rd_tready_i;
    assign rd_tvalid_o = cnt_q != '0;
    assign rd_tdata_o  = mem_q[rd_ptr_q];
    assign count_o     = cnt_q;

    // Pointers and occupancy; pointers wrap at DEPTH so any depth works.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_tvalid_i) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(wr_tvalid_i) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (wr_tvalid_i) begin
            mem_q[wr_ptr_q] <= wr_tdata_i;
        end
    end

    // Results cannot be stalled, so a push into a full FIFO is a credit bug upstream.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_tvalid_i && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/pes_fmul_arbiter.sv
// rtl/pes_fmul_arbiter.sv - round-robin sharing of one pipelined FP32 multiplier; option PES_FMUL_ZERO_FIX_EN
module pes_fmul_arbiter
    import pes_fmul_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int RSP_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [FP32_W*NREQ-1:0] req_a,
    input  logic [FP32_W*NREQ-1:0] req_b,
    output logic [FP32_W-1:0]      mul_a,
    output logic [FP32_W-1:0]      mul_b,
    input  logic [FP32_W-1:0]      mul_f,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [FP32_W*NREQ-1:0] rsp_data,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CRW   = $clog2(RSP_DEPTH + 1);

`ifdef PES_FMUL_ZERO_FIX_EN
    typedef dl_entry_t dl_t;
`else
    typedef dl_base_t dl_t;
`endif

    logic [PTR_W-1:0]  ptr_q;
    logic [CRW-1:0]    credit_q [NREQ];
    logic [CRW-1:0]    fifo_cnt [NREQ];
    logic [FP32_W-1:0] mul_a_q, mul_b_q;
    dl_t               dl_q [MUL_LAT+1];
    dl_t               dl_d;
    dl_t               head;

    logic [NREQ-1:0]   elig, gnt, push, pop;
    logic              found, acc, dl_busy;
    logic [PTR_W-1:0]  gnt_idx;
    int                idx;
    logic [FP32_W-1:0] gnt_a, gnt_b, push_data;

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign acc       = found && rst;
    assign gnt       = acc ? (NREQ'(1) << gnt_idx) : '0;
    assign req_ready = gnt;
    assign gnt_a     = req_a[int'(gnt_idx)*FP32_W +: FP32_W];
    assign gnt_b     = req_b[int'(gnt_idx)*FP32_W +: FP32_W];
    assign head      = dl_q[MUL_LAT];

    // A requester competes only while it holds a response-slot credit.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (credit_q[i] != '0);
        end
    end

    // Round-robin pick: first eligible requester after the last winner.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    // Entry launched into the delay line alongside the operands.
    always_comb begin
        dl_d       = '0;
        dl_d.valid = acc;
        dl_d.tag   = TAG_W'(gnt_idx);
`ifdef PES_FMUL_ZERO_FIX_EN
        dl_d.zflag = exp_is_zero(gnt_a) || exp_is_zero(gnt_b);
        dl_d.zsign = gnt_a[FP32_W-1] ^ gnt_b[FP32_W-1];
`endif
    end

    // Operand registers, pointer and tag delay line; the line shifts every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
            ptr_q   <= PTR_W'(NREQ - 1);
            for (int k = 0; k <= MUL_LAT; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            if (acc) begin
                mul_a_q <= gnt_a;
                mul_b_q <= gnt_b;
                ptr_q   <= gnt_idx;
            end
            dl_q[0] <= dl_d;
            for (int k = 1; k <= MUL_LAT; k++) begin
                dl_q[k] <= dl_q[k-1];
            end
        end
    end

    // Product routing: the last stage lines up with mul_f.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            push[i] = head.valid && (head.tag == TAG_W'(i));
        end
`ifdef PES_FMUL_ZERO_FIX_EN
        push_data = head.zflag ? {head.zsign, {(FP32_W-1){1'b0}}} : mul_f;
`else
        push_data = mul_f;
`endif
    end

    // Credits: spent at grant, returned at pop; both in one cycle cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= CRW'(RSP_DEPTH);
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= credit_q[i] - CRW'(gnt[i]) + CRW'(pop[i]);
            end
        end
    end

    // Activity: anything in the multiplier shadow or any queued result.
    always_comb begin
        dl_busy = 1'b0;
        for (int k = 0; k <= MUL_LAT; k++) begin
            dl_busy = dl_busy | dl_q[k].valid;
        end
        busy = dl_busy | (|rsp_valid);
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        int infl;

        assign pop[i] = rsp_valid[i] && rsp_ready[i];

        pes_fmul_rsp_fifo #(
            .DEPTH(RSP_DEPTH),
            .WIDTH(FP32_W)
        ) u_fifo (
            .clk_i      (clk),
            .rst_ni     (rst),
            .wr_tvalid_i(push[i]),
            .wr_tdata_i (push_data),
            .rd_tvalid_o(rsp_valid[i]),
            .rd_tready_i(rsp_ready[i]),
            .rd_tdata_o (rsp_data[FP32_W*i +: FP32_W]),
            .count_o    (fifo_cnt[i])
        );

        // Operations of this requester still travelling through the multiplier.
        always_comb begin
            infl = 0;
            for (int k = 0; k <= MUL_LAT; k++) begin
                if (dl_q[k].valid && dl_q[k].tag == TAG_W'(i)) begin
                    infl = infl + 1;
                end
            end
        end

        assert property (@(posedge clk) disable iff (!rst)
            int'(credit_q[i]) + infl + int'(fifo_cnt[i]) == RSP_DEPTH);
    end

endmodule

// File: doc/pes_fmul_arbiter.md
Name: pes_fmul_arbiter

Overview:
- Shares one pipelined FP32 multiplier (pes_pipeline_mul style: operands sampled every clock, no valid, no stall, fixed latency) among NREQ requesters.
- Round-robin grants one operand pair per cycle, drives the multiplier operand registers and tracks requester tags through a delay line matched to multiplier latency.
- Routes each product into a per-requester response FIFO. Per-requester credits guarantee a non-stallable result always has a slot.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 4, edges from mul_a/mul_b change to matching mul_f change.
- RSP_DEPTH, 2, per-requester response FIFO depth (power of 2, >=1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  operand pair offered by requester i.
- req_ready  out  NREQ  grant/accept; one-hot or zero.
- req_a  in  32*NREQ  FP32 operand A, slice i = [32i+31:32i].
- req_b  in  32*NREQ  FP32 operand B.
- mul_a  out  32  registered operand A to multiplier.
- mul_b  out  32  registered operand B to multiplier.
- mul_f  in  32  multiplier product.
- rsp_valid  out  NREQ  FIFO i non-empty.
- rsp_ready  in  NREQ  pop FIFO i.
- rsp_data  out  32*NREQ  head of FIFO i.
- busy  out  1  any op in flight or any FIFO non-empty.

Behaviour:
- Reset (rst=0, async): mul_a=mul_b=0, delay-line valids 0, FIFOs empty, credits=RSP_DEPTH, rr pointer=NREQ-1, all req_ready/rsp_valid=0, busy=0.
- Eligible(i) = req_valid[i] && credit[i]!=0. req_ready[i] is combinational: the first eligible requester searching from ptr+1 upward, modulo NREQ. At most one bit is set. req_ready never asserts without req_valid.
- On accept of i at edge t:
  - mul_a/mul_b <= req_a[i]/req_b[i].
  - Delay-line stage0 <= {valid=1, tag=i}.
  - ptr <= i.
  - credit[i] decrements.
- With no accept, mul_a/mul_b hold and stage0.valid <= 0. The pointer is unchanged.
- Delay line has MUL_LAT+1 stages and shifts every edge unconditionally. At edge t+MUL_LAT, stage MUL_LAT aligns with mul_f. At edge t+MUL_LAT+1, mul_f is pushed into FIFO[tag]. rsp_valid[i] is visible from that edge, so handshake-to-rsp_valid is MUL_LAT+1 cycles (5 by default).
- Pop when rsp_valid[i]&&rsp_ready[i]: credit[i] increments. A grant and a pop to the same i in one cycle leave the credit unchanged.
- The credit invariant credit+in_flight+occupancy==RSP_DEPTH holds per requester, so a FIFO push never hits full. An assertion checks this; push-on-full is a design error.
- Order is preserved per requester. Throughput is 1 op/cycle aggregate and RSP_DEPTH ops in flight per requester.
- Credit 0 with req_valid high means not eligible: no grant, and the pointer does not advance.
- Reset mid-operation discards in-flight tags and FIFO contents. Stale mul_f values are never captured because valids are 0.
- busy = OR(delay-line valids) | OR(rsp_valid).

Optional Feature:
- Macro: PES_FMUL_ZERO_FIX_EN.
- Defined:
  - At grant, zero flag = (a[30:23]==0)||(b[30:23]==0), i.e. zero/denormal operands are flushed.
  - The flag and sign a[31]^b[31] travel in the delay line.
  - When the flag is set, FIFO push data = {sign,31'b0} instead of mul_f.
  - Latency and ordering are unchanged.
- Undefined: mul_f is stored raw, and the delay line carries only valid+tag.

Decomposition:
- Package pes_fmul_pkg holds:
  - FP32_W=32, EXP_W=8, MAN_W=23, FP_BIAS=8'h7F.
  - Default MUL_LAT=4.
  - Delay-line entry struct {valid, tag[$clog2(NREQ)], zflag, zsign}.
- Sub-module pes_fmul_rsp_fifo: sync FIFO, parameters DEPTH/WIDTH, async active-low reset. NREQ instances are generated.

Test Plan:
- Single op: requester 0 sends 0x40000000 x 0x40000000 (2.0x2.0). req_ready[0] asserts the same cycle, mul_a=0x40000000 after the edge, and rsp_valid[0] rises exactly 5 cycles later with rsp_data[0]=0x40800000.
- Contention, all 4 requesters valid continuously with rsp_ready=1: grants go 0,1,2,3,0,... one per cycle. Requester i sends 1.0x1.0 with sign a[31]=i[0], and responses are 0x3F800000 or 0xBF800000 per requester sign, in order.
- Credits: requester 2 sends 3 ops back-to-back with rsp_ready[2]=0, RSP_DEPTH=2. Only 2 are accepted and req_ready[2] stays 0. After one pop, the third is accepted on the next cycle.
- Simultaneous grant and pop on requester 1 over 20 cycles: credit stays constant and no FIFO overflow assertion fires.
- Reset asserted 2 cycles after 3 grants: all rsp_valid=0, busy=0 and credits=2 immediately. No response appears within 10 cycles after release.
- With PES_FMUL_ZERO_FIX_EN: 0x00000000 x 0xC0000000 gives 0x80000000. Without it, rsp_data equals the mul_f sampled at the aligned cycle.
